// File: rtl/mux_sel_arbiter_8.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter_8
//
// Round-robin arbiter that drives the Sel/Enable pair of the 8-way bus
// multiplexer in the VGA write path. One source owns the bus at a time. The
// owner keeps the grant for as long as it keeps requesting. A one-cycle
// turnaround gap separates two owners. Every output comes from a register, so
// the multiplexer only ever sees clean select values.
//
// Optional feature (compile-time macro MUX_ARB_TIMEOUT_EN):
//   When the macro is defined, an owner keeps the bus for at most MaxHold
//   consecutive cycles. At that point the arbiter forces a gap and pulses
//   Timeout for that gap cycle. When the macro is undefined, a grant lasts
//   indefinitely, Timeout is tied low and MaxHold has no effect.
//
// Parameters:
//   MaxHold  maximum consecutive granted cycles per owner (1..255)
//
// Ports:
//   Clock    in   1  system clock, rising edge
//   nReset   in   1  asynchronous active-low reset
//   Req      in   8  per-source request, bit i = mux input i
//   Grant    out  8  one-hot grant, zero when nobody owns the bus
//   Sel      out  3  index of the current or most recent owner
//   Enable   out  1  high while an owner holds the bus
//   Busy     out  1  high in GRANT and GAP
//   Timeout  out  1  one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module mux_sel_arbiter_8 #(
    parameter int unsigned MaxHold = 16
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [7:0] Req,
    output logic [7:0] Grant,
    output logic [2:0] Sel,
    output logic       Enable,
    output logic       Busy,
    output logic       Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] grant_q, grant_d;
    logic       enable_q, enable_d;
    logic       busy_q, busy_d;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(MaxHold - 1);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    // Arbitration: rotate Req so that index ptr_q lands at bit 0. The lowest
    // set bit of the rotated vector is then the winner's offset from ptr_q.
    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_idx;
    logic        win_valid;

    always_comb begin
        req_dbl   = {Req, Req} >> ptr_q;
        req_rot   = req_dbl[7:0];
        win_off   = '0;
        win_valid = |Req;
        // The loop runs downward, so the lowest set offset is assigned last.
        for (int unsigned i = 8; i > 0; i--) begin
            if (req_rot[i-1]) win_off = 3'(i - 1);
        end
        win_idx = ptr_q + win_off;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        sel_d    = sel_q;
        grant_d  = '0;
        enable_d = 1'b0;
        busy_d   = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_valid) begin
                    state_d  = ST_GRANT;
                    owner_d  = win_idx;
                    sel_d    = win_idx;
                    grant_d  = 8'b1 << win_idx;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d   = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A natural release is tested first, so it takes precedence
                // over a timeout that falls due on the same edge.
                if (!Req[owner_q]) begin
                    state_d = ST_GAP;
                    ptr_d   = owner_q + 3'd1;
                    busy_d  = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                end else if (hold_q == HoldLast) begin
                    state_d   = ST_GAP;
                    ptr_d     = owner_q + 3'd1;
                    busy_d    = 1'b1;
                    timeout_d = 1'b1;
`endif
                end else begin
                    grant_d  = grant_q;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d   = hold_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            sel_q    <= '0;
            grant_q  <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
`endif

    assign Grant  = grant_q;
    assign Sel    = sel_q;
    assign Enable = enable_q;
    assign Busy   = busy_q;

endmodule
